// File: rtl/display_arbiter_if.sv
// Display arbiter bus: requester-side request/data lines and the arbitrated
// display outputs. The master modport is the requester/driver side; the slave
// modport is the arbiter.
interface display_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]         req;
  logic [32*NUM_REQ-1:0]      data;
  logic [NUM_REQ-1:0]         grant;
  logic [$clog2(NUM_REQ)-1:0] owner_idx;
  logic                       busy;
  logic [31:0]                display_bcd;
  logic                       scan_tick;

  modport master (
    output req,
    output data,
    input  grant,
    input  owner_idx,
    input  busy,
    input  display_bcd,
    input  scan_tick
  );

  modport slave (
    input  req,
    input  data,
    output grant,
    output owner_idx,
    output busy,
    output display_bcd,
    output scan_tick
  );
endinterface

// File: rtl/display_arbiter.sv
// display_arbiter: shares the 8-digit seven-segment display between NUM_REQ
// requesters with round-robin, minimum-hold time slots, and generates the
// digit scanner's refresh strobe.
//
// Optional build macro DISPLAY_ARB_PRIORITY_EN: requester 0 becomes urgent. It
// pre-empts any other owner on the next edge and is never rotated out by the
// hold limit. Without the macro all requesters are treated alike.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | nobody owns the display, BLANK_BCD shown, busy low
// OWNED | owner holds the display, hold counter runs toward the limit
module display_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter int          HOLD_CYCLES = 100_000_000,
  parameter int          SCAN_DIV    = 100_000,
  parameter logic [31:0] BLANK_BCD   = 32'hAAAA_AAAA
) (
  input logic              clk,
  input logic              reset_n,
  display_arbiter_if.slave bus
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   owner, owner_next;
  logic [IDX_W-1:0]   last, last_next;
  logic [HOLD_W-1:0]  hold_cnt, hold_next;
  logic [SCAN_W-1:0]  scan_cnt, scan_next;

  logic [NUM_REQ-1:0] grant_q, grant_next;
  logic [31:0]        bcd_q, bcd_next;
  logic               tick_q;

  logic [NUM_REQ-1:0] owner_oh;
  logic [IDX_W:0]     idle_pick;
  logic [IDX_W:0]     other_pick;
  logic               hold_done;
  logic               new_grant;

  // Circular search: the first set bit of mask strictly after position 'after',
  // wrapping around so that 'after' itself is tried last. Returns {found, idx}.
  // Scanning from farthest to nearest lets the nearest hit win.
  function automatic logic [IDX_W:0] pick_next(
    input logic [NUM_REQ-1:0] mask,
    input logic [IDX_W-1:0]   after
  );
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] pos;
    int               idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(after) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      pos = IDX_W'(idx);
      if (mask[pos]) begin
        res = {1'b1, pos};
      end
    end
    return res;
  endfunction

  // Candidate owners: from IDLE the search starts after the last-served
  // requester; while owned it starts after the current owner and skips it.
  always_comb begin
    owner_oh   = NUM_REQ'(1) << owner;
    idle_pick  = pick_next(bus.req, last);
    other_pick = pick_next(bus.req & ~owner_oh, owner);
`ifdef DISPLAY_ARB_PRIORITY_EN
    hold_done  = (hold_cnt == HOLD_MAX) && (owner != '0);
`else
    hold_done  = (hold_cnt == HOLD_MAX);
`endif
  end

  // Next state and next owner. A release takes precedence over hold expiry,
  // so both resolve to the same handoff target.
  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (idle_pick[IDX_W]) begin
          state_next = OWNED;
          owner_next = idle_pick[IDX_W-1:0];
        end
      end
      OWNED: begin
        if (!bus.req[owner]) begin
          if (other_pick[IDX_W]) begin
            owner_next = other_pick[IDX_W-1:0];
          end else begin
            state_next = IDLE;
            owner_next = '0;
          end
        end else if (hold_done && other_pick[IDX_W]) begin
          owner_next = other_pick[IDX_W-1:0];
        end
      end
      default: begin
        state_next = IDLE;
        owner_next = '0;
      end
    endcase
`ifdef DISPLAY_ARB_PRIORITY_EN
    if (bus.req[0] && !(state == OWNED && owner == '0)) begin
      state_next = OWNED;
      owner_next = '0;
    end
`endif
  end

  // Values loaded into the output and counter registers on the next edge.
  always_comb begin
    new_grant  = (state_next == OWNED) && ((state == IDLE) || (owner_next != owner));
    last_next  = new_grant ? owner_next : last;
    grant_next = '0;
    bcd_next   = BLANK_BCD;
    if (state_next == OWNED) begin
      grant_next = NUM_REQ'(1) << owner_next;
      bcd_next   = bus.data[{owner_next, 5'b0} +: 32];
    end
    if ((state_next == IDLE) || new_grant) begin
      hold_next = '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_next = hold_cnt + 1'b1;
    end else begin
      hold_next = hold_cnt;
    end
    scan_next = (scan_cnt == SCAN_MAX) ? '0 : scan_cnt + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Owner, pointer, counters and registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner    <= '0;
      last     <= LAST_INIT;
      hold_cnt <= '0;
      scan_cnt <= '0;
      grant_q  <= '0;
      bcd_q    <= BLANK_BCD;
      tick_q   <= 1'b0;
    end else begin
      owner    <= owner_next;
      last     <= last_next;
      hold_cnt <= hold_next;
      scan_cnt <= scan_next;
      grant_q  <= grant_next;
      bcd_q    <= bcd_next;
      tick_q   <= (scan_next == SCAN_MAX);
    end
  end

  assign bus.grant       = grant_q;
  assign bus.owner_idx   = owner;
  assign bus.busy        = (state == OWNED);
  assign bus.display_bcd = bcd_q;
  assign bus.scan_tick   = tick_q;

endmodule
